// File: rtl/if_id_stage_if.sv
// if_id_stage_if: fetch-side, hazard-side and decode-side signals of the IF/ID latch
interface if_id_stage_if #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 16
);
  logic              ihit;
  logic              dhit;
  logic              dmem_pend;
  logic              hazard;
  logic              branch;
  logic              jump;
  logic [WORD_W-1:0] imemload;
  logic [WORD_W-1:0] npc_in;
  logic [WORD_W-1:0] instr_out;
  logic [WORD_W-1:0] npc_out;
  logic              valid_out;
  logic              pc_en;
  logic              halted;
  logic              flush_pend;
  logic [CNT_W-1:0]  bubble_cnt;
  modport master (
    output ihit, dhit, dmem_pend, hazard, branch, jump, imemload, npc_in,
    input  instr_out, npc_out, valid_out, pc_en, halted, flush_pend, bubble_cnt
  );
  modport slave (
    input  ihit, dhit, dmem_pend, hazard, branch, jump, imemload, npc_in,
    output instr_out, npc_out, valid_out, pc_en, halted, flush_pend, bubble_cnt
  );
endinterface

// File: rtl/if_id_stage.sv
// if_id_stage: IF/ID pipeline latch turning stalls and flushes into held or bubbled decode slots
module if_id_stage #(
  parameter int              WORD_W   = 32,
  parameter int              CNT_W    = 16,
  parameter logic [WORD_W-1:0] NOP_WORD = '0,
  parameter logic [5:0]      HALT_OP  = 6'b111111
) (
  input logic           CLK,
  input logic           RST,
  if_id_stage_if.slave  bus
);
  logic [WORD_W-1:0] r_instr;
  logic [WORD_W-1:0] r_npc;
  logic              r_valid;
  logic              r_halted;
  logic              r_flush_pend;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_mem_stall;
  logic              w_flush;
  logic              w_active;
  logic              w_bubble;
  logic              w_load;
  logic              w_halt_hit;
  logic              w_flush_pend_nxt;
  // Decode the priority ladder into bubble/load/flush-tracking decisions for this edge
  always_comb begin
    w_mem_stall      = bus.dmem_pend & ~bus.dhit;
    w_flush          = bus.branch | bus.jump;
    w_active         = ~r_halted & ~w_mem_stall;
    w_bubble         = w_active & (w_flush | (r_flush_pend & bus.ihit) | (~bus.hazard & ~bus.ihit));
    w_load           = w_active & ~w_flush & ~r_flush_pend & ~bus.hazard & bus.ihit;
    w_halt_hit       = w_load & (bus.imemload[WORD_W-1 -: 6] == HALT_OP);
    w_flush_pend_nxt = r_halted ? r_flush_pend
                     : w_mem_stall ? (r_flush_pend | w_flush)
                     : w_flush ? ~bus.ihit
                     : (r_flush_pend & ~bus.ihit);
  end
  // Latch state; reset beats halt and any pending flush
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_instr      <= NOP_WORD;
      r_npc        <= '0;
      r_valid      <= 1'b0;
      r_halted     <= 1'b0;
      r_flush_pend <= 1'b0;
      r_cnt        <= '0;
    end else begin
      if (w_bubble) begin
        r_instr <= NOP_WORD;
        r_valid <= 1'b0;
      end else if (w_load) begin
        r_instr <= bus.imemload;
        r_npc   <= bus.npc_in;
        r_valid <= 1'b1;
      end
      if (w_halt_hit) r_halted <= 1'b1;
      r_flush_pend <= w_flush_pend_nxt;
      if (w_bubble && r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
    end
  end
  assign bus.instr_out  = r_instr;
  assign bus.npc_out    = r_npc;
  assign bus.valid_out  = r_valid;
  assign bus.halted     = r_halted;
  assign bus.flush_pend = r_flush_pend;
  assign bus.bubble_cnt = r_cnt;
  assign bus.pc_en      = bus.ihit & ~bus.hazard & ~w_mem_stall & ~r_halted & ~RST;
endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: table-driven IF/ID latch bench with an expected-result queue
module tb_if_id_stage;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;
  if_id_stage_if #(.WORD_W(32), .CNT_W(16)) b ();
  if_id_stage_if #(.WORD_W(32), .CNT_W(2))  b2 ();
  if_id_stage #(.WORD_W(32), .CNT_W(16)) dut (.CLK(CLK), .RST(RST), .bus(b));
  if_id_stage #(.WORD_W(32), .CNT_W(2))  dut2 (.CLK(CLK), .RST(RST), .bus(b2));
  typedef struct {
    logic        ih, dh, dp, hz, br, jp;
    logic [31:0] im, np;
    logic [31:0] ei, en;
    logic        ev, ep, eh, ef;
    logic [15:0] ec;
  } vec_t;
  vec_t tv[17];
  vec_t q[$];
  logic [15:0] cq[$];
  int n_vec = 0;
  int n_err = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input vec_t v);
    b.ihit = v.ih; b.dhit = v.dh; b.dmem_pend = v.dp; b.hazard = v.hz;
    b.branch = v.br; b.jump = v.jp; b.imemload = v.im; b.npc_in = v.np;
  endtask
  task automatic chk_regs(input string tag, input vec_t e);
    chk({tag, " instr_out"}, b.instr_out, e.ei);
    chk({tag, " npc_out"}, b.npc_out, e.en);
    chk({tag, " valid_out"}, 32'(b.valid_out), 32'(e.ev));
    chk({tag, " halted"}, 32'(b.halted), 32'(e.eh));
    chk({tag, " flush_pend"}, 32'(b.flush_pend), 32'(e.ef));
    chk({tag, " bubble_cnt"}, 32'(b.bubble_cnt), 32'(e.ec));
  endtask
  vec_t z, e;
  initial begin
    //          ih dh dp hz br jp  imemload       npc_in  | instr_out      npc_out ev ep eh ef cnt
    tv[0]  = '{1, 0, 0, 0, 0, 0, 32'h2001_0005, 32'h04, 32'h2001_0005, 32'h04, 1, 1, 0, 0, 0};
    tv[1]  = '{1, 0, 0, 1, 0, 0, 32'h1111_1111, 32'h08, 32'h2001_0005, 32'h04, 1, 0, 0, 0, 0};
    tv[2]  = '{1, 0, 0, 1, 0, 0, 32'h1111_1111, 32'h08, 32'h2001_0005, 32'h04, 1, 0, 0, 0, 0};
    tv[3]  = '{0, 0, 0, 0, 1, 0, 32'h0,         32'h08, 32'h0,         32'h04, 0, 0, 0, 1, 1};
    tv[4]  = '{1, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 32'h0C, 32'h0,         32'h04, 0, 1, 0, 0, 2};
    tv[5]  = '{1, 0, 0, 0, 0, 0, 32'h0022_1820, 32'h10, 32'h0022_1820, 32'h10, 1, 1, 0, 0, 2};
    tv[6]  = '{1, 0, 1, 0, 0, 1, 32'hAAAA_0000, 32'h14, 32'h0022_1820, 32'h10, 1, 0, 0, 1, 2};
    tv[7]  = '{1, 0, 1, 0, 0, 0, 32'hAAAA_0000, 32'h14, 32'h0022_1820, 32'h10, 1, 0, 0, 1, 2};
    tv[8]  = '{0, 0, 1, 0, 0, 0, 32'hAAAA_0000, 32'h14, 32'h0022_1820, 32'h10, 1, 0, 0, 1, 2};
    tv[9]  = '{1, 1, 1, 0, 0, 0, 32'hBBBB_0000, 32'h18, 32'h0,         32'h10, 0, 1, 0, 0, 3};
    tv[10] = '{1, 0, 0, 0, 0, 0, 32'h8C22_0004, 32'h1C, 32'h8C22_0004, 32'h1C, 1, 1, 0, 0, 3};
    tv[11] = '{0, 0, 0, 0, 0, 0, 32'h0,         32'h20, 32'h0,         32'h1C, 0, 0, 0, 0, 4};
    tv[12] = '{0, 0, 0, 1, 0, 0, 32'h0,         32'h20, 32'h0,         32'h1C, 0, 0, 0, 0, 4};
    tv[13] = '{1, 0, 0, 0, 0, 1, 32'hCCCC_0000, 32'h20, 32'h0,         32'h1C, 0, 1, 0, 0, 5};
    tv[14] = '{1, 0, 0, 0, 0, 0, 32'hFC00_0000, 32'h24, 32'hFC00_0000, 32'h24, 1, 1, 1, 0, 5};
    tv[15] = '{1, 0, 0, 0, 1, 0, 32'h1234_5678, 32'h28, 32'hFC00_0000, 32'h24, 1, 0, 1, 0, 5};
    tv[16] = '{0, 0, 0, 0, 0, 1, 32'h0,         32'h2C, 32'hFC00_0000, 32'h24, 1, 0, 1, 0, 5};
    z = '{0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 0};
    drive(z);
    b2.ihit = 0; b2.dhit = 0; b2.dmem_pend = 0; b2.hazard = 0;
    b2.branch = 0; b2.jump = 0; b2.imemload = '0; b2.npc_in = '0;
    b.ihit = 1'b1;
    @(posedge CLK); #1;
    chk("pc_en in reset", 32'(b.pc_en), 32'h0);
    @(negedge CLK);
    b.ihit = 1'b0;
    RST = 1'b0;
    chk_regs("reset", z);
    for (int i = 0; i < 17; i++) begin
      drive(tv[i]);
      #1;
      chk($sformatf("v%0d pc_en", i), 32'(b.pc_en), 32'(tv[i].ep));
      q.push_back(tv[i]);
      @(posedge CLK); #1;
      e = q.pop_front();
      chk_regs($sformatf("v%0d", i), e);
      @(negedge CLK);
    end
    drive(tv[15]);
    RST = 1'b1;
    #1;
    chk("pc_en mid reset", 32'(b.pc_en), 32'h0);
    @(posedge CLK); #1;
    chk_regs("mid reset", z);
    chk("cnt2 reset", 32'(b2.bubble_cnt), 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    drive(z);
    for (int i = 1; i <= 5; i++) begin
      cq.push_back(16'(i > 3 ? 3 : i));
      @(posedge CLK); #1;
      chk($sformatf("cnt2 bubble %0d", i), 32'(b2.bubble_cnt), 32'(cq.pop_front()));
      @(negedge CLK);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Fetch/decode pipeline latch between instruction fetch and decode.
- Consumes the hazard unit's outputs: hazard stall, branch and jump flush, and dhit.
- Holds the fetched instruction and its next-PC for decode.
- Converts stalls and flushes into held or bubbled decode slots; tracks flushes that arrive while instruction memory is busy; counts inserted bubbles.

Parameters:
- WORD_W, 32, instruction and PC width.
- CNT_W, 16, bubble counter width (saturating).
- NOP_WORD, 32'h00000000, encoding written on a bubble.
- HALT_OP, 6'b111111, opcode that freezes the stage.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- ihit  in  1  instruction memory returned imemload this cycle.
- dhit  in  1  data access completed this cycle (MEM stage).
- dmem_pend  in  1  MEM stage has a load or store outstanding.
- hazard  in  1  load-use stall request from the hazard unit.
- branch  in  1  taken branch resolved; flush fetch/decode.
- jump  in  1  jump resolved; flush fetch/decode.
- imemload  in  WORD_W  fetched instruction.
- npc_in  in  WORD_W  PC+4 of fetched instruction.
- instr_out  out  WORD_W  instruction presented to decode.
- npc_out  out  WORD_W  next-PC presented to decode.
- valid_out  out  1  instr_out is a real instruction (0 = bubble).
- pc_en  out  1  fetch PC may advance this cycle.
- halted  out  1  HALT captured; stage frozen.
- flush_pend  out  1  flush recorded, awaiting wrong-path fetch.
- bubble_cnt  out  CNT_W  bubbles inserted since reset.

Behaviour:
- Reset (RST=1 at posedge) values:
  - instr_out=NOP_WORD, npc_out=0, valid_out=0.
  - halted=0, flush_pend=0, bubble_cnt=0.
  - pc_en=0 combinationally while RST=1.
- mem_stall = dmem_pend & ~dhit. While mem_stall=1 the whole latch holds, including flush_pend and the counter. A flush arriving during mem_stall is recorded into flush_pend.
- Per-edge priority, evaluated when RST=0:
  1. halted=1: hold everything.
  2. mem_stall=1: hold. If (branch|jump), set flush_pend=1.
  3. (branch|jump) & ihit: load bubble, clear flush_pend.
  4. (branch|jump) & ~ihit: load bubble, set flush_pend=1.
  5. flush_pend & ihit: discard imemload (wrong path), load bubble, clear flush_pend.
  6. hazard=1: hold instr_out, npc_out and valid_out; do not load.
  7. ihit=1: load imemload and npc_in, set valid_out=1. If imemload[31:26]==HALT_OP, set halted=1 on the same edge.
  8. else (~ihit): load bubble.
- "Load bubble" means: instr_out=NOP_WORD, valid_out=0, npc_out unchanged.
- bubble_cnt increments by 1 on every edge that loads a bubble (cases 3, 4, 5, 8). It saturates at all-ones; no wrap. Holds (cases 1, 2, 6) do not count.
- pc_en = ihit & ~hazard & ~mem_stall & ~halted & ~RST. A flush does not gate pc_en, because the PC is redirected by the branch/jump path.
- Latency: an instruction presented with ihit appears on instr_out one cycle later.
- Mid-operation RST overrides every case, including halted and flush_pend.

Test Plan:
- Reset, then imemload=32'h2001_0005 and npc_in=4 with ihit=1 for one edge:
  - Next cycle: instr_out=32'h20010005, npc_out=4, valid_out=1, pc_en=1 during the fetch cycle.
- Captured instruction, then hazard=1 and ihit=1 for 2 cycles:
  - instr_out held, valid_out=1, pc_en=0, bubble_cnt unchanged.
- branch=1 with ihit=0:
  - Next: valid_out=0, flush_pend=1, bubble_cnt+1.
- Follow-up to the previous case: ihit=1 with imemload=32'hDEAD_BEEF:
  - DEADBEEF never appears on instr_out; bubble loaded, flush_pend=0, bubble_cnt+2 total.
- dmem_pend=1 and dhit=0 for 3 cycles while jump=1 in the first cycle:
  - Outputs held, pc_en=0, flush_pend=1.
  - After dhit=1, the next ihit word is discarded.
- ihit with imemload=32'hFC00_0000 (HALT):
  - halted=1 next cycle, pc_en=0 thereafter.
  - Further ihit or branch has no effect until RST=1 clears every output to its reset value.
- Force CNT_W=2 and inject 5 bubbles:
  - bubble_cnt reads 0,1,2,3,3,3.
